// File: rtl/alu_op_issuer_if.sv
// Command, ALU operand/result and response signals of the ALU op issuer.
// master = issuer side, slave = surrounding command source, ALU and response sink.
interface alu_op_issuer_if #(
  parameter int W_DATA_IN  = 8,
  parameter int W_DATA_OP  = 2,
  parameter int W_DATA_OUT = 8
);
  logic                  i_cmd_valid;
  logic                  o_cmd_ready;
  logic [W_DATA_IN-1:0]  i_cmd_a;
  logic [W_DATA_IN-1:0]  i_cmd_b;
  logic [W_DATA_OP-1:0]  i_cmd_op;
  logic [W_DATA_IN-1:0]  o_alu_a;
  logic [W_DATA_IN-1:0]  o_alu_b;
  logic [W_DATA_OP-1:0]  o_alu_op;
  logic [W_DATA_OUT-1:0] i_alu_result;
  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [W_DATA_OUT-1:0] o_rsp_result;
  logic [W_DATA_OP-1:0]  o_rsp_op;
  logic                  o_rsp_err;
  logic                  o_busy;

  modport master (
    input  i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_op, i_alu_result, i_rsp_ready,
    output o_cmd_ready, o_alu_a, o_alu_b, o_alu_op, o_rsp_valid, o_rsp_result,
           o_rsp_op, o_rsp_err, o_busy
  );

  modport slave (
    output i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_op, i_alu_result, i_rsp_ready,
    input  o_cmd_ready, o_alu_a, o_alu_b, o_alu_op, o_rsp_valid, o_rsp_result,
           o_rsp_op, o_rsp_err, o_busy
  );
endinterface

// File: rtl/alu_op_issuer.sv
// Issues one ALU operation at a time, waits out the ALU latency and returns the result.
// Optional ALU_ISSUER_DIV0_GUARD_EN: divide-by-zero answered locally with all-ones and err=1.
module alu_op_issuer #(
  parameter int W_DATA_IN   = 8,
  parameter int W_DATA_OP   = 2,
  parameter int W_DATA_OUT  = 8,
  parameter int ALU_LATENCY = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  alu_op_issuer_if.master bus
);
  localparam int CNT_W = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LATENCY);
  localparam logic [W_DATA_OP-1:0] OP_DIV = W_DATA_OP'(3);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      bus.o_cmd_ready  <= 1'b1;
      bus.o_busy       <= 1'b0;
      bus.o_alu_a      <= '0;
      bus.o_alu_b      <= '0;
      bus.o_alu_op     <= '0;
      bus.o_rsp_valid  <= 1'b0;
      bus.o_rsp_result <= '0;
      bus.o_rsp_op     <= '0;
      bus.o_rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_cmd_valid) begin
            bus.o_cmd_ready <= 1'b0;
            bus.o_busy      <= 1'b1;
`ifdef ALU_ISSUER_DIV0_GUARD_EN
            // Divide-by-zero never reaches the ALU; the response is formed here.
            if (bus.i_cmd_op == OP_DIV && bus.i_cmd_b == '0) begin
              state            <= RESP;
              bus.o_rsp_result <= '1;
              bus.o_rsp_op     <= OP_DIV;
              bus.o_rsp_err    <= 1'b1;
            end else
`endif
            begin
              state        <= WAIT;
              cnt          <= '0;
              bus.o_alu_a  <= bus.i_cmd_a;
              bus.o_alu_b  <= bus.i_cmd_b;
              bus.o_alu_op <= bus.i_cmd_op;
            end
          end
        end
        WAIT: begin
          if (cnt == CNT_LAST) begin
            state            <= RESP;
            cnt              <= '0;
            bus.o_rsp_valid  <= 1'b1;
            bus.o_rsp_result <= bus.i_alu_result;
            bus.o_rsp_op     <= bus.o_alu_op;
            bus.o_rsp_err    <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          // Locally formed responses enter RESP one edge before valid rises.
          if (!bus.o_rsp_valid) begin
            bus.o_rsp_valid <= 1'b1;
          end else if (bus.i_rsp_ready) begin
            state           <= IDLE;
            bus.o_rsp_valid <= 1'b0;
            bus.o_cmd_ready <= 1'b1;
            bus.o_busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
